sdf_r2_stage: RTL

- Parametrised radix-2 single-path delay-feedback (SDF) NTT stage; successor to the fixed-size sdf_top datapath.
- Delay depth is a parameter, and the stage is bubble-tolerant: it advances only on valid input.
- Adds a per-frame inverse mode that applies a 1/2 scaling (Gentleman-Sande INTT).
- log2(N) instances chain, with DELAY_LOG2 decreasing by one per stage, to form a full N-point NTT/INTT.

---
 rtl/sdf_r2_stage.sv | 123 ++++++++++++
 1 files changed

// File: rtl/sdf_r2_stage.sv
// Radix-2 single-path delay-feedback NTT/INTT butterfly stage with a parametrised delay
// depth. The stage advances only on accepted samples and can scale its results by 1/2 for inverse transforms.
module sdf_r2_stage #(
  parameter int unsigned               DATA_WIDTH = 64,
  parameter logic [DATA_WIDTH-1:0]     MODULO     = 7681,
  parameter int unsigned               DELAY_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  inv_mode,
  output logic [DELAY_LOG2-1:0] tw_addr,
  input  logic [DATA_WIDTH-1:0] tw_in,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  frame_done
);

  localparam int unsigned W = DATA_WIDTH;
  localparam int unsigned D = 2 ** DELAY_LOG2;
  localparam logic [W:0]          MOD_X    = {1'b0, MODULO};
  localparam logic [2*W-1:0]      MOD_W    = {{W{1'b0}}, MODULO};
  localparam logic [DELAY_LOG2:0] CNT_LAST = {(DELAY_LOG2+1){1'b1}};

  function automatic logic [W-1:0] mod_add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= MOD_X) s = s - MOD_X;
    return s[W-1:0];
  endfunction

  function automatic logic [W-1:0] mod_sub(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] d;
    if (a < b) d = {1'b0, a} + MOD_X - {1'b0, b};
    else       d = {1'b0, a} - {1'b0, b};
    return d[W-1:0];
  endfunction

  function automatic logic [W-1:0] mod_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] p;
    logic [2*W-1:0] r;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    r = p % MOD_W;
    return r[W-1:0];
  endfunction

  // Halving mod an odd prime: odd values borrow one modulus so the shift stays exact.
  function automatic logic [W-1:0] scale_half(input logic [W-1:0] v, input logic inv);
    logic [W:0] t;
    if (!inv) return v;
    t = v[0] ? ({1'b0, v} + MOD_X) : {1'b0, v};
    return t[W:1];
  endfunction

  logic [DELAY_LOG2:0] cnt;
  logic                primed;
  logic                mode_q;
  logic                second_half;
  logic [W-1:0]        dly [D];
  logic [W-1:0]        head;

  logic [W-1:0]        sum_p0;
  logic [W-1:0]        diff_p0;
  logic [W-1:0]        prod_p0;
  logic [W-1:0]        push_p0;

  logic                vld_p1;
  logic [W-1:0]        out_data_p1;
  logic                frame_done_p1;

  assign second_half = cnt[DELAY_LOG2];
  assign head        = dly[D-1];
  assign tw_addr     = cnt[DELAY_LOG2-1:0];

  // Stage p0: butterfly on (delay head, incoming sample), scaled before leaving the stage.
  always_comb begin
    sum_p0  = scale_half(mod_add(head, in_data), mode_q);
    diff_p0 = mod_sub(head, in_data);
    prod_p0 = scale_half(mod_mul(diff_p0, tw_in), mode_q);
    push_p0 = second_half ? prod_p0 : in_data;
  end

  always_ff @(posedge clk) begin
    if (in_valid) begin
      dly[0] <= push_p0;
      for (int i = 1; i < D; i++) dly[i] <= dly[i-1];
    end
  end

  // Stage p1: registered output and frame bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt           <= '0;
      primed        <= 1'b0;
      mode_q        <= 1'b0;
      vld_p1        <= 1'b0;
      out_data_p1   <= '0;
      frame_done_p1 <= 1'b0;
    end else begin
      vld_p1        <= 1'b0;
      frame_done_p1 <= 1'b0;
      if (in_valid) begin
        cnt           <= cnt + 1'b1;
        frame_done_p1 <= (cnt == CNT_LAST);
        if (cnt == '0) mode_q <= inv_mode;
        if (second_half) begin
          out_data_p1 <= sum_p0;
          vld_p1      <= 1'b1;
          primed      <= 1'b1;
        end else begin
          out_data_p1 <= head;
          vld_p1      <= primed;
        end
      end
    end
  end

  assign out_valid  = vld_p1;
  assign out_data   = out_data_p1;
  assign frame_done = frame_done_p1;

endmodule
